// File: rtl/bsg_cache_dma_to_simple_mem.sv
// Bridge from bsg_cache DMA packets to a single-word valid/ready memory port.
// One packet is serviced at a time; read responses are buffered and returned to the cache in order.
module bsg_cache_dma_to_simple_mem #(
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int resp_fifo_els_p       = 2,
    parameter int mem_addr_width_p      = addr_width_p - $clog2(data_width_p >> 3)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [addr_width_p:0]       dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,
    output logic [data_width_p-1:0]     dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_i,
    input  logic [data_width_p-1:0]     dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o,
    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [mem_addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0]     mem_data_o,
    input  logic                        mem_ready_i,
    input  logic [data_width_p-1:0]     mem_data_i,
    input  logic                        mem_v_i
);
    localparam int ByteOffW = $clog2(data_width_p >> 3);
    localparam int CntW     = $clog2(block_size_in_words_p + 1);
    localparam int CredW    = $clog2(resp_fifo_els_p + 1);
    localparam int PtrW     = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;

    localparam logic [CntW-1:0]             LastBeat   = CntW'(block_size_in_words_p - 1);
    localparam logic [CntW-1:0]             NumBeats   = CntW'(block_size_in_words_p);
    localparam logic [CntW-1:0]             CntOne     = CntW'(1);
    localparam logic [CredW-1:0]            NumCredits = CredW'(resp_fifo_els_p);
    localparam logic [CredW-1:0]            CredOne    = CredW'(1);
    localparam logic [PtrW-1:0]             LastPtr    = PtrW'(resp_fifo_els_p - 1);
    localparam logic [PtrW-1:0]             PtrOne     = PtrW'(1);
    localparam logic [mem_addr_width_p-1:0] BlockMask  = ~mem_addr_width_p'(block_size_in_words_p - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e                      r_state;
    logic [mem_addr_width_p-1:0] r_base;
    logic [CntW-1:0]             r_beat;
    logic [CntW-1:0]             r_delivered;
    logic [CredW-1:0]            r_outstanding;
    logic [CredW-1:0]            r_fifoCount;
    logic [PtrW-1:0]             r_rdPtr;
    logic [PtrW-1:0]             r_wrPtr;
    logic [data_width_p-1:0]     r_fifoMem [resp_fifo_els_p];

    logic [mem_addr_width_p-1:0] w_baseAddr;
    logic                        w_creditOk;
    logic                        w_memAccept;
    logic                        w_readAccept;
    logic                        w_fifoPush;
    logic                        w_fifoPop;
    logic                        w_fifoNonEmpty;

    generate
        if (ByteOffW > 0) begin : g_lowBits
            logic w_unusedLowBits;
            assign w_unusedLowBits = ^dma_pkt_i[ByteOffW-1:0];
        end
    endgenerate

    assign w_baseAddr     = dma_pkt_i[addr_width_p-1:ByteOffW] & BlockMask;
    assign w_creditOk     = (r_outstanding + r_fifoCount) < NumCredits;
    assign w_memAccept    = mem_v_o & mem_ready_i;
    assign w_readAccept   = w_memAccept & (r_state == READ);
    assign w_fifoPush     = mem_v_i & (r_state == READ) & (r_outstanding != '0);
    assign w_fifoNonEmpty = (r_fifoCount != '0);
    assign w_fifoPop      = w_fifoNonEmpty & dma_data_ready_i;
    assign dma_data_v_o   = w_fifoNonEmpty;
    assign dma_data_o     = w_fifoNonEmpty ? r_fifoMem[r_rdPtr] : '0;

    // The request holds once raised: only an accept adds to outstanding+occupancy, so credit never shrinks early.
    always_comb begin
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_v_o         = 1'b0;
        mem_w_o         = 1'b0;
        mem_addr_o      = '0;
        mem_data_o      = '0;
        case (r_state)
            IDLE: dma_pkt_yumi_o = dma_pkt_v_i & ~reset_i;
            WRITE: begin
                mem_v_o         = dma_data_v_i;
                mem_w_o         = 1'b1;
                mem_addr_o      = r_base + mem_addr_width_p'(r_beat);
                mem_data_o      = dma_data_i;
                dma_data_yumi_o = dma_data_v_i & mem_ready_i;
            end
            READ: begin
                mem_v_o    = (r_beat < NumBeats) & w_creditOk;
                mem_addr_o = r_base + mem_addr_width_p'(r_beat);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_beat        <= '0;
            r_delivered   <= '0;
            r_outstanding <= '0;
            r_fifoCount   <= '0;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dma_pkt_v_i) begin
                        r_base  <= w_baseAddr;
                        r_state <= dma_pkt_i[addr_width_p] ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (w_memAccept) begin
                        if (r_beat == LastBeat) begin
                            r_beat  <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_beat <= r_beat + CntOne;
                        end
                    end
                end
                READ: begin
                    if (w_readAccept) r_beat <= r_beat + CntOne;
                    // Every issue and response is done once the last beat leaves the buffer.
                    if (w_fifoPop) begin
                        if (r_delivered == LastBeat) begin
                            r_delivered <= '0;
                            r_beat      <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_delivered <= r_delivered + CntOne;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            case ({w_readAccept, w_fifoPush})
                2'b10:   r_outstanding <= r_outstanding + CredOne;
                2'b01:   r_outstanding <= r_outstanding - CredOne;
                default: ;
            endcase
            case ({w_fifoPush, w_fifoPop})
                2'b10:   r_fifoCount <= r_fifoCount + CredOne;
                2'b01:   r_fifoCount <= r_fifoCount - CredOne;
                default: ;
            endcase
            if (w_fifoPush) r_wrPtr <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + PtrOne;
            if (w_fifoPop)  r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fifoPush) r_fifoMem[r_wrPtr] <= mem_data_i;
    end

    // A response with nothing outstanding is dropped; flag it so the environment bug is visible.
    assert property (@(posedge clk_i) disable iff (reset_i)
        mem_v_i |-> ((r_state == READ) && (r_outstanding != '0)));

endmodule

// File: tb/tb_bsg_cache_dma_to_simple_mem.sv
// Directed bench for the DMA-to-simple-memory bridge: memory model with random latency,
// evict-data driver and fill monitor, checked step by step with immediate assertions.
module tb_bsg_cache_dma_to_simple_mem;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BS  = 8;
    localparam int FE  = 2;
    localparam int MAW = 30;

    logic          clk;
    logic          reset;
    logic [AW:0]   dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_i;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_yumi_o;
    logic          mem_v_o;
    logic          mem_w_o;
    logic [MAW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ready_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_v_i;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [DW-1:0]     memArr [logic [MAW-1:0]];
    logic [DW-1:0]     refMem [logic [MAW-1:0]];
    logic [DW-1:0]     evictQ[$];
    logic [DW-1:0]     fillLog[$];
    logic [DW-1:0]     pendData[$];
    int                pendDue[$];
    logic [MAW-1:0]    rdAddrLog[$];
    logic [MAW+DW-1:0] wrLog[$];

    int   outstanding = 0;
    int   maxOutstanding = 0;
    int   yumiViolations = 0;
    int   pktCount = 0;
    int   lastPopCyc = -10;
    int   acceptGap = 0;
    int   readyMode = 0;
    int   latMin = 1;
    int   latMax = 1;
    logic fillStall = 1'b0;
    logic fillRandom = 1'b0;

    bsg_cache_dma_to_simple_mem #(
        .addr_width_p(AW),
        .data_width_p(DW),
        .block_size_in_words_p(BS),
        .resp_fifo_els_p(FE)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .dma_pkt_i(dma_pkt_i),
        .dma_pkt_v_i(dma_pkt_v_i),
        .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_o(dma_data_o),
        .dma_data_v_o(dma_data_v_o),
        .dma_data_ready_i(dma_data_ready_i),
        .dma_data_i(dma_data_i),
        .dma_data_v_i(dma_data_v_i),
        .dma_data_yumi_o(dma_data_yumi_o),
        .mem_v_o(mem_v_o),
        .mem_w_o(mem_w_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i),
        .mem_data_i(mem_data_i),
        .mem_v_i(mem_v_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] initPattern(input logic [MAW-1:0] a);
        return 32'hC0DE0000 ^ {2'b00, a};
    endfunction

    function automatic logic [DW-1:0] expVal(input logic [MAW-1:0] a);
        return refMem.exists(a) ? refMem[a] : initPattern(a);
    endfunction

    // Memory model, evict-data consumption and fill capture, all sampled at the active edge.
    always @(posedge clk) begin
        if (reset) begin
            pendData.delete();
            pendDue.delete();
            evictQ.delete();
            outstanding = 0;
        end else begin
            if (mem_v_o && mem_ready_i) begin
                if (mem_w_o) begin
                    memArr[mem_addr_o] = mem_data_o;
                    wrLog.push_back({mem_addr_o, mem_data_o});
                end else begin
                    rdAddrLog.push_back(mem_addr_o);
                    pendData.push_back(memArr.exists(mem_addr_o) ? memArr[mem_addr_o] : initPattern(mem_addr_o));
                    pendDue.push_back(cyc + int'($urandom_range(latMax, latMin)));
                    outstanding++;
                end
            end
            if (mem_v_i) outstanding--;
            if (outstanding > maxOutstanding) maxOutstanding = outstanding;
            if (dma_data_yumi_o) begin
                if (!mem_ready_i) yumiViolations++;
                if (evictQ.size() > 0) void'(evictQ.pop_front());
            end
            if (dma_data_v_o && dma_data_ready_i) begin
                fillLog.push_back(dma_data_o);
                lastPopCyc = cyc;
            end
            if (dma_pkt_v_i && dma_pkt_yumi_o) begin
                pktCount++;
                acceptGap = cyc - lastPopCyc;
            end
        end
        cyc++;
    end

    // Environment-side inputs change only on the falling edge.
    always @(negedge clk) begin
        mem_v_i = 1'b0;
        mem_data_i = '0;
        if (!reset && pendDue.size() > 0 && pendDue[0] <= cyc) begin
            mem_v_i = 1'b1;
            mem_data_i = pendData.pop_front();
            void'(pendDue.pop_front());
        end
        mem_ready_i = (readyMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        dma_data_ready_i = fillStall ? 1'b0 : (fillRandom ? ($urandom_range(0, 3) != 0) : 1'b1);
        dma_data_v_i = (evictQ.size() > 0);
        dma_data_i = (evictQ.size() > 0) ? evictQ[0] : '0;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendPkt(input logic wr, input logic [AW-1:0] addr, output logic ok);
        ok = 1'b0;
        dma_pkt_i = {wr, addr};
        dma_pkt_v_i = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            #1;
            ok = dma_pkt_yumi_o;
            @(negedge clk);
        end
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] seed);
        logic ok;
        logic done;
        int fill0;
        int wr0;
        int rd0;
        logic [MAW-1:0] base;
        base = addr[AW-1:2] & ~MAW'(BS - 1);
        fill0 = fillLog.size();
        wr0 = wrLog.size();
        rd0 = rdAddrLog.size();
        if (wr) begin
            for (int k = 0; k < BS; k++) begin
                evictQ.push_back(seed + DW'(k));
                refMem[base + MAW'(k)] = seed + DW'(k);
            end
        end
        sendPkt(wr, addr, ok);
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            done = wr ? (wrLog.size() >= wr0 + BS) : (fillLog.size() >= fill0 + BS);
            if (!done) @(negedge clk);
        end
        checkOutput({tag, ".accepted"}, 64'(ok), 64'd1);
        checkOutput({tag, ".done"}, 64'(done), 64'd1);
        if (done) begin
            for (int k = 0; k < BS; k++) begin
                if (wr) begin
                    checkOutput($sformatf("%s.write%0d", tag, k), 64'(wrLog[wr0 + k]),
                                64'({base + MAW'(k), seed + DW'(k)}));
                end else begin
                    checkOutput($sformatf("%s.rdAddr%0d", tag, k), 64'(rdAddrLog[rd0 + k]), 64'(base + MAW'(k)));
                    checkOutput($sformatf("%s.fill%0d", tag, k), 64'(fillLog[fill0 + k]), 64'(expVal(base + MAW'(k))));
                end
            end
        end
    endtask

    initial begin
        logic ok;
        logic done;
        int rd0;
        int wr0;
        int fill0;
        int pk0;
        int yumiSeen;

        reset = 1'b1;
        dma_pkt_i = '0;
        dma_pkt_v_i = 1'b0;
        dma_data_ready_i = 1'b1;
        dma_data_i = '0;
        dma_data_v_i = 1'b0;
        mem_ready_i = 1'b1;
        mem_data_i = '0;
        mem_v_i = 1'b0;

        // Reset holds every output low even with a packet offered.
        repeat (3) @(negedge clk);
        dma_pkt_i = {1'b0, 32'h1234};
        dma_pkt_v_i = 1'b1;
        #1;
        checkOutput("reset.ctl", 64'({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, mem_v_o, mem_w_o}), 64'd0);
        checkOutput("reset.memAddr", 64'(mem_addr_o), 64'd0);
        checkOutput("reset.memData", 64'(mem_data_o), 64'd0);
        checkOutput("reset.fillData", 64'(dma_data_o), 64'd0);
        dma_pkt_v_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Read of 0x1234: words 0x488..0x48F, memory preload pattern C0DE0000^addr.
        rd0 = rdAddrLog.size();
        fill0 = fillLog.size();
        applyStimulus("read1234", 1'b0, 32'h1234, '0);
        checkOutput("read1234.firstAddrHand", 64'(rdAddrLog[rd0]), 64'h488);
        checkOutput("read1234.firstFillHand", 64'(fillLog[fill0]), 64'hC0DE0488);
        checkOutput("read1234.lastFillHand", 64'(fillLog[fill0 + 7]), 64'hC0DE048F);

        // Write of 0x40 with a stuttering memory: words 0x10..0x17 get A0..A7.
        readyMode = 1;
        wr0 = wrLog.size();
        applyStimulus("write40", 1'b1, 32'h40, 32'hA0);
        checkOutput("write40.firstHand", 64'(wrLog[wr0]), {2'b00, 30'h10, 32'hA0});
        checkOutput("write40.yumiOnlyWithReady", 64'(yumiViolations), 64'd0);
        applyStimulus("readBack40", 1'b0, 32'h40, '0);

        // Top of address space.
        readyMode = 0;
        applyStimulus("topRead", 1'b0, 32'hFFFF_FFFC, '0);
        applyStimulus("topWrite", 1'b1, 32'hFFFF_FFE0, 32'h5500);
        applyStimulus("topReadBack", 1'b0, 32'hFFFF_FFE4, '0);

        // Cache stalls fill data for 20 cycles while a second packet waits.
        latMin = 1;
        latMax = 1;
        fillStall = 1'b1;
        rd0 = rdAddrLog.size();
        fill0 = fillLog.size();
        pk0 = pktCount;
        sendPkt(1'b0, 32'h200, ok);
        checkOutput("stall.accepted", 64'(ok), 64'd1);
        dma_pkt_i = {1'b0, 32'h0A0};
        dma_pkt_v_i = 1'b1;
        yumiSeen = 0;
        repeat (20) begin
            #1;
            if (dma_pkt_yumi_o) yumiSeen++;
            @(negedge clk);
        end
        #1;
        checkOutput("stall.readsIssued", 64'(rdAddrLog.size() - rd0), 64'd2);
        checkOutput("stall.fillValid", 64'(dma_data_v_o), 64'd1);
        checkOutput("stall.noYumiInRead", 64'(yumiSeen), 64'd0);
        fillStall = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = (pktCount >= pk0 + 2);
        end
        dma_pkt_v_i = 1'b0;
        checkOutput("stall.secondAccepted", 64'(done), 64'd1);
        checkOutput("stall.backToBackGap", 64'(acceptGap), 64'd1);
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            done = (fillLog.size() >= fill0 + 2 * BS);
            if (!done) @(negedge clk);
        end
        checkOutput("stall.allFills", 64'(done), 64'd1);
        if (done) begin
            for (int k = 0; k < BS; k++) begin
                checkOutput($sformatf("stall.fillA%0d", k), 64'(fillLog[fill0 + k]), 64'(initPattern(30'h80 + MAW'(k))));
                checkOutput($sformatf("stall.fillB%0d", k), 64'(fillLog[fill0 + BS + k]), 64'(initPattern(30'h28 + MAW'(k))));
            end
        end

        // Reset while beat 3 of a write is on the memory port.
        wr0 = wrLog.size();
        for (int k = 0; k < BS; k++) evictQ.push_back(32'hB0 + DW'(k));
        sendPkt(1'b1, 32'h300, ok);
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            done = (wrLog.size() >= wr0 + 3);
            if (!done) @(negedge clk);
        end
        #2;
        checkOutput("midWrite.reached", 64'(done), 64'd1);
        checkOutput("midWrite.memV", 64'(mem_v_o), 64'd1);
        checkOutput("midWrite.addr", 64'(mem_addr_o), 64'hC3);
        checkOutput("midWrite.data", 64'(mem_data_o), 64'hB3);
        reset = 1'b1;
        #1;
        checkOutput("midWrite.resetCtl", 64'({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, mem_v_o, mem_w_o}), 64'd0);
        checkOutput("midWrite.resetAddr", 64'(mem_addr_o), 64'd0);
        checkOutput("midWrite.resetData", 64'(mem_data_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midWrite.beatsBeforeReset", 64'(wrLog.size() - wr0), 64'd3);
        applyStimulus("postReset", 1'b0, 32'h1234, '0);

        // Mixed traffic over a small window so reads observe earlier writes.
        readyMode = 1;
        latMin = 1;
        latMax = 10;
        fillRandom = 1'b1;
        for (int p = 0; p < 300; p++) begin
            applyStimulus($sformatf("rand%0d", p), 1'($urandom_range(0, 1)),
                          32'(($urandom_range(0, 15) << 5) | $urandom_range(0, 31)), 32'($urandom));
        end
        checkOutput("rand.yumiOnlyWithReady", 64'(yumiViolations), 64'd0);
        checkOutput("maxOutstanding", 64'(maxOutstanding), 64'(FE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
